// File: rtl/mandel_pkg.sv
// mandel_pkg: shared fixed-point types, constants and FSM states for the Mandelbrot engine.
package mandel_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 28;
  typedef logic signed [DATA_W-1:0] fx_t;
  localparam fx_t TWO_FX = fx_t'(2) << FRAC_W;
  localparam fx_t FOUR_FX = fx_t'(4) << FRAC_W;
  // ADD is the second half of an evaluation, reached only with the registered-multiplier build
  typedef enum logic [1:0] {IDLE, ITER, ADD, DONE} state_t;
endpackage

// File: rtl/fx_mul.sv
// fx_mul: signed fixed-point multiply, full product shifted right by F and truncated to W bits.
module fx_mul
  import mandel_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int F = FRAC_W
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_p
);
  // Sign-extended operands make the low 2W product bits equal the signed product.
  assign o_p = W'(({{W{i_a[W-1]}}, i_a} * {{W{i_b[W-1]}}, i_b}) >> F);
endmodule

// File: rtl/mandel_iter.sv
// mandel_iter: handshaked per-pixel escape-time engine iterating z <- z^2 + c.
// Define MANDEL_ITER_REG_MULT_EN to register the multipliers (two cycles per evaluation).
module mandel_iter
  import mandel_pkg::*;
#(
  parameter int ITER_W = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_im,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic              diverged,
  output logic [9:0]        x_out,
  output logic [9:0]        y_out
);
  state_t r_state, w_next;
  fx_t r_cre, r_cim, r_zr, r_zi;
  fx_t w_zr2, w_zi2, w_zrzi, w_pr, w_pi, w_px;
  logic [9:0] r_x, r_y;
  logic [ITER_W-1:0] r_count, w_cnt_nx;
  logic r_div, w_escape, w_fin;
  logic [DATA_W:0] w_mag;

  fx_mul u_zr2  (.i_a(r_zr), .i_b(r_zr), .o_p(w_zr2));
  fx_mul u_zi2  (.i_a(r_zi), .i_b(r_zi), .o_p(w_zi2));
  fx_mul u_zrzi (.i_a(r_zr), .i_b(r_zi), .o_p(w_zrzi));

`ifdef MANDEL_ITER_REG_MULT_EN
  localparam state_t EVAL = ADD;
  fx_t r_zr2, r_zi2, r_zrzi;
  always_ff @(posedge clk)
    if (r_state == ITER) begin
      r_zr2  <= w_zr2;
      r_zi2  <= w_zi2;
      r_zrzi <= w_zrzi;
    end
  assign w_pr = r_zr2;
  assign w_pi = r_zi2;
  assign w_px = r_zrzi;
`else
  localparam state_t EVAL = ITER;
  assign w_pr = w_zr2;
  assign w_pi = w_zi2;
  assign w_px = w_zrzi;
`endif

  // Squares are non-negative, so the magnitude sum is compared unsigned with one guard bit.
  assign w_mag    = {1'b0, w_pr} + {1'b0, w_pi};
  assign w_escape = (r_zr >= TWO_FX) || (r_zr <= -TWO_FX) || (r_zi >= TWO_FX) ||
                    (r_zi <= -TWO_FX) || (w_mag > {1'b0, FOUR_FX});
  assign w_cnt_nx = r_count + 1'b1;
  assign w_fin    = w_escape || (w_cnt_nx == ITER_W'(MAX_ITER));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = in_valid ? ITER : IDLE;
      ITER:    w_next = (EVAL == ADD) ? ADD : (w_fin ? DONE : ITER);
      ADD:     w_next = w_fin ? DONE : ITER;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    r_state <= !rst ? IDLE : w_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cre   <= '0;
      r_cim   <= '0;
      r_zr    <= '0;
      r_zi    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_count <= '0;
      r_div   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_cre   <= c_re;
      r_cim   <= c_im;
      r_zr    <= '0;
      r_zi    <= '0;
      r_x     <= x_in;
      r_y     <= y_in;
      r_count <= '0;
      r_div   <= 1'b0;
    end else if (r_state == EVAL) begin
      if (w_escape) r_div <= 1'b1;
      else begin
        r_zr    <= w_pr - w_pi + r_cre;
        r_zi    <= (w_px <<< 1) + r_cim;
        r_count <= w_cnt_nx;
      end
    end
  end

  assign in_ready   = rst && (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign iter_count = r_count;
  assign diverged   = r_div;
  assign x_out      = r_x;
  assign y_out      = r_y;
endmodule

// File: tb/tb_mandel_iter.sv
// tb_mandel_iter: directed self-checking bench for the Mandelbrot escape-time engine.
module tb_mandel_iter;
  import mandel_pkg::*;
`ifdef MANDEL_ITER_REG_MULT_EN
  localparam int REG = 1;
`else
  localparam int REG = 0;
`endif
  localparam int MAXI = 255;
  localparam logic [31:0] HALF = 32'h0800_0000;
  localparam logic [31:0] ONE5 = 32'h1800_0000;
  localparam logic [31:0] NEG1 = 32'hF000_0000;

  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, diverged;
  logic [31:0] c_re = 0, c_im = 0;
  logic [9:0] x_in = 0, y_in = 0, x_out, y_out;
  logic [7:0] iter_count;
  int n_pass = 0, n_tot = 0, lat;
  bit rdy_seen, stable;

  mandel_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .c_re(c_re), .c_im(c_im), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready), .iter_count(iter_count),
    .diverged(diverged), .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int esc_lat(input int n);
    return REG ? 2 * n + 3 : n + 2;
  endfunction

  function automatic int cap_lat();
    return REG ? 2 * MAXI + 1 : MAXI + 1;
  endfunction

  task automatic accept(input logic [31:0] re, input logic [31:0] im, input int x, input int y);
    @(negedge clk);
    c_re = re; c_im = im; x_in = 10'(x); y_in = 10'(y); in_valid = 1;
    chk("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done(output int l, output bit seen);
    l = 0;
    seen = 0;
    do begin
      @(negedge clk);
      l++;
      seen |= in_ready;
    end while (!out_valid && l < 2000);
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("ready_after_done", int'(in_ready), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(iter_count), 0);
    rst = 1;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);

    accept(32'h0, 32'h0, 1, 2);
    wait_done(lat, rdy_seen);
    chk("c0_latency", lat, cap_lat());
    chk("c0_ready_low", int'(rdy_seen), 0);
    chk("c0_count", int'(iter_count), 255);
    chk("c0_diverged", int'(diverged), 0);
    handshake();

    accept(HALF, 32'h0, 17, 42);
    wait_done(lat, rdy_seen);
    chk("half_latency", lat, esc_lat(5));
    chk("half_count", int'(iter_count), 5);
    chk("half_diverged", int'(diverged), 1);
    chk("half_x", int'(x_out), 17);
    chk("half_y", int'(y_out), 42);
    handshake();

    accept(ONE5, ONE5, 5, 6);
    wait_done(lat, rdy_seen);
    chk("c15_latency", lat, esc_lat(1));
    chk("c15_count", int'(iter_count), 1);
    chk("c15_diverged", int'(diverged), 1);
    handshake();

    accept(NEG1, 32'h0, 100, 200);
    wait_done(lat, rdy_seen);
    chk("neg1_latency", lat, cap_lat());
    chk("neg1_count", int'(iter_count), 255);
    chk("neg1_diverged", int'(diverged), 0);
    c_re = HALF; x_in = 10'd9; y_in = 10'd9; in_valid = 1;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stable &= out_valid && !in_ready && iter_count == 8'd255 && !diverged &&
                x_out == 10'd100 && y_out == 10'd200;
    end
    in_valid = 0;
    chk("neg1_hold_stable", int'(stable), 1);
    handshake();
    @(negedge clk);
    chk("no_spurious_accept", int'(out_valid), 0);

    accept(32'h0, 32'h0, 3, 4);
    repeat (20) @(negedge clk);
    chk("mid_iter_busy", int'(in_ready), 0);
    rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_count", int'(iter_count), 0);
    chk("midrst_x", int'(x_out), 0);
    chk("midrst_y", int'(y_out), 0);
    rst = 1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    accept(HALF, 32'h0, 17, 42);
    wait_done(lat, rdy_seen);
    chk("post_rst_latency", lat, esc_lat(5));
    chk("post_rst_count", int'(iter_count), 5);
    chk("post_rst_diverged", int'(diverged), 1);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mandel_iter.md
# mandel_iter

Per-pixel Mandelbrot escape-time engine. Accepts one complex point c (from the coordinate mapper) with its pixel coordinates over a valid/ready handshake. Iterates z ← z² + c in signed fixed point until escape or an iteration cap, then presents the iteration count, a diverged flag and the pixel coordinates downstream to the frame-RAM write / colour stage. It replaces the separate diverge and iteration-counter pair with one handshaked stage.

## Interface
- DATA_W, 32: fixed-point word width of c and z (signed, two's complement)
- FRAC_W, 28: fraction bits (Q4.28, range [-8, 8))
- ITER_W, 8: width of iteration count
- MAX_ITER, 255: iteration cap, 1 ≤ MAX_ITER ≤ 2^ITER_W − 1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  c_re/c_im/x_in/y_in valid
- in_ready  out  1  engine can accept a point
- c_re  in  DATA_W  real part of c; caller guarantees |c_re| < 2.0
- c_im  in  DATA_W  imaginary part of c; caller guarantees |c_im| < 2.0
- x_in, y_in  in  10 each  pixel coordinates, carried through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- iter_count  out  ITER_W  completed updates before escape, or MAX_ITER
- diverged  out  1  1 = escaped, 0 = hit cap
- x_out, y_out  out  10 each  coordinates of the point being reported

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch c, x, y; set z = 0 and count = 0; go to ITER.
- ITER, one evaluation per cycle, in this order:
  - Escape test: escape if |zr| ≥ 2.0, or |zi| ≥ 2.0, or zr²+zi² > 4.0.
    - Compare the sum unsigned in DATA_W+1 bits.
    - Squares are full signed products, arithmetically shifted right by FRAC_W and truncated to DATA_W.
  - Escape → diverged = 1, go to DONE; count unchanged.
  - Otherwise update:
    - zr ← zr² − zi² + c_re
    - zi ← 2·zr·zi + c_im
    - count ← count + 1
  - If the new count equals MAX_ITER → diverged = 0, go to DONE.
  - Input bounds and the escape test together guarantee |z| < 6, so no saturation logic exists.
- DONE:
  - out_valid = 1; iter_count, diverged, x_out, y_out held stable.
  - On out_ready → IDLE.
- in_ready = 0 in ITER and DONE. There is no bypass: a new point is accepted only from IDLE.
- Reset (rst low) in any state, including mid-ITER or in DONE with out_ready low:
  - next state IDLE; the in-flight point is discarded.
  - out_valid = 0, diverged = 0, iter_count = 0, x_out = y_out = 0.
  - in_ready is forced 0 while rst is low.

## Timing
- Accept at edge T → first ITER evaluation in cycle T+1.
- Escape after n updates → n+1 ITER cycles; out_valid rises at edge T+n+2.
- Cap reached → MAX_ITER ITER cycles; out_valid rises at edge T+MAX_ITER+1.
- DONE lasts ≥1 cycle. Handshake at edge D → in_ready = 1 in cycle D+1.
- Minimum accept-to-accept interval = n+3 cycles.

## Configuration
- MANDEL_ITER_REG_MULT_EN defined:
  - A register is inserted after the three multipliers; ITER splits into substates MUL and ADD.
  - Each evaluation takes 2 cycles, so all ITER-phase latencies above double.
  - Results are bit-identical.
- Undefined: single-cycle evaluation as specified above.

## Structure
- Shared package mandel_pkg holds:
  - DATA_W and FRAC_W defaults
  - constants TWO_FX = 2 << FRAC_W and FOUR_FX = 4 << FRAC_W
  - typedef fx_t (signed DATA_W)
  - the state enum
- One sub-module, fx_mul: signed DATA_W×DATA_W multiply, >>FRAC_W, truncate to DATA_W. Instantiated three times (zr², zi², zr·zi).

## Test plan
- c = (0.0, 0.0), out_ready = 1:
  - iter_count = 255, diverged = 0.
  - out_valid at T+256 after accept; in_ready low throughout.
- c = (0.5, 0.0), x = 17, y = 42:
  - iter_count = 5, diverged = 1, x_out = 17, y_out = 42.
  - out_valid at T+7.
- c = (1.5, 1.5):
  - iter_count = 1, diverged = 1 (zr²+zi² = 4.5 at z1).
- c = (−1.0, 0.0):
  - iter_count = 255, diverged = 0 (period-2 orbit 0, −1).
  - Hold out_ready low 10 cycles: outputs stable, in_valid ignored.
- Pull rst low mid-ITER of c = (0, 0), then release:
  - next cycle: IDLE, out_valid = 0, outputs 0.
  - in_ready = 1 one cycle after release; the next point is processed correctly.
- Repeat scenario 2 with MANDEL_ITER_REG_MULT_EN defined:
  - same count and flag.
  - out_valid at T+13.
